// File: rtl/barrel_shifter_pipe.sv
// -----------------------------------------------------------------------------
// barrel_shifter_pipe
//
// Pipelined barrel shifter / rotator. One operand enters per cycle. It passes
// through SHW registered mux stages. Stage j shifts by 2^j when bit j of the
// operand's amount is set. A sideband tag travels with every operand, so each
// result can be matched to its request.
//
// Operations (in_op):
//   3'b000 ROL   out[i] = in[(i-k) mod WIDTH]
//   3'b001 ROR   out[i] = in[(i+k) mod WIDTH]
//   3'b010 SLL   zero fill from the LSB side
//   3'b011 SRL   zero fill from the MSB side
//   3'b100 SRA   fill with the operand's sign bit
//   3'b101..111  pass-through, the amount is ignored
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high; flushes every stage
//   in_valid   operand presented this cycle
//   in_ready   block accepts an operand this cycle
//   in_data    operand, WIDTH bits
//   in_amt     shift/rotate amount, SHW bits
//   in_op      operation select, 3 bits
//   in_tag     sideband tag, TAG_W bits, returned unchanged
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_data   result, WIDTH bits
//   out_tag    tag belonging to out_data
//
// Handshake: a transfer happens on a side when its valid and ready are both
// high at a rising edge. The whole pipe moves as one unit. It advances when
// the last stage is empty or being drained (advance = out_ready ||
// !out_valid). Otherwise every stage holds. in_ready equals advance, so the
// input side never waits on anything except the output side. Bubbles are
// carried along and are not squeezed out, so the latency is always exactly
// SHW cycles. While the output is stalled, out_data and out_tag stay stable.
// -----------------------------------------------------------------------------
module barrel_shifter_pipe #(
  parameter  int WIDTH = 16,
  parameter  int TAG_W = 4,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [2:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [2:0] OP_ROL = 3'b000;
  localparam logic [2:0] OP_ROR = 3'b001;
  localparam logic [2:0] OP_SLL = 3'b010;
  localparam logic [2:0] OP_SRL = 3'b011;
  localparam logic [2:0] OP_SRA = 3'b100;

  // Everything one operand needs on its way down the pipe. The full amount
  // and op go along to every stage; each stage looks only at its own amount
  // bit.
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] data;
    logic [SHW-1:0]   amt;
    logic [2:0]       op;
    logic [TAG_W-1:0] tag;
  } stage_t;

  stage_t in_stage;
  stage_t stg_d [SHW];
  stage_t stg_q [SHW];
  logic   advance;

  // One mux step: apply op by a fixed distance s (1 <= s <= WIDTH/2).
  // Pass-through codes fall into the default and leave the data untouched.
  function automatic logic [WIDTH-1:0] shift_step(
    input logic [WIDTH-1:0] d,
    input logic [2:0]       op,
    input int               s
  );
    logic [WIDTH-1:0] r;
    r = d;
    case (op)
      OP_ROL:  r = (d << s) | (d >> (WIDTH - s));
      OP_ROR:  r = (d >> s) | (d << (WIDTH - s));
      OP_SLL:  r = d << s;
      OP_SRL:  r = d >> s;
      OP_SRA:  r = $unsigned($signed(d) >>> s);
      default: r = d;
    endcase
    return r;
  endfunction

  assign advance  = out_ready || !stg_q[SHW-1].valid;
  assign in_ready = advance;

  // Operand fields are zeroed when no operand is presented. Bubbles then
  // carry clean zeros instead of whatever is on the input bus.
  always_comb begin
    in_stage = '0;
    if (in_valid) begin
      in_stage.valid = 1'b1;
      in_stage.data  = in_data;
      in_stage.amt   = in_amt;
      in_stage.op    = in_op;
      in_stage.tag   = in_tag;
    end
  end

  // Next value of every stage register. Stage 0 works on the incoming
  // operand; stage j works on the output of stage j-1.
  always_comb begin
    stg_d[0] = in_stage;
    if (in_stage.amt[0]) begin
      stg_d[0].data = shift_step(in_stage.data, in_stage.op, 1);
    end
    for (int j = 1; j < SHW; j++) begin
      stg_d[j] = stg_q[j-1];
      if (stg_q[j-1].amt[j]) begin
        stg_d[j].data = shift_step(stg_q[j-1].data, stg_q[j-1].op, 1 << j);
      end
    end
  end

  // A full reset clear also forces out_data and out_tag to zero. Any operands
  // in flight are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < SHW; j++) begin
        stg_q[j] <= '0;
      end
    end else if (advance) begin
      for (int j = 0; j < SHW; j++) begin
        stg_q[j] <= stg_d[j];
      end
    end
  end

  assign out_valid = stg_q[SHW-1].valid;
  assign out_data  = stg_q[SHW-1].data;
  assign out_tag   = stg_q[SHW-1].tag;

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// -----------------------------------------------------------------------------
// tb_barrel_shifter_pipe
//
// Directed bench for barrel_shifter_pipe at WIDTH=16, TAG_W=4. The expected
// results are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_barrel_shifter_pipe;

  localparam int WIDTH = 16;
  localparam int TAG_W = 4;
  localparam int SHW   = 4;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_amt;
  logic [2:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [TAG_W-1:0] out_tag;

  int checks   = 0;
  int failures = 0;

  // expected result queue for the backpressure segment
  logic [WIDTH-1:0] exp_q[$];
  logic [TAG_W-1:0] exp_tag_q[$];

  barrel_shifter_pipe #(
    .WIDTH (WIDTH),
    .TAG_W (TAG_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_op     (in_op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  // ---------------------------------------------------------------- clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- driver
  // Advance one clock and settle 1 time unit past the edge. Checks and new
  // input values both happen at that point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic [3:0] a,
                       input logic [2:0] o, input logic [3:0] t);
    in_valid = v;
    in_data  = d;
    in_amt   = a;
    in_op    = o;
    in_tag   = t;
  endtask

  task automatic idle();
    drive(1'b0, 16'h0000, 4'd0, 3'd0, 4'd0);
  endtask

  // Send one operand into an empty pipe and check the timing of its result.
  // Nothing comes out for the first 3 cycles. The result appears exactly 4
  // cycles after the accept, then leaves once with no duplicate.
  task automatic run_single(input string name, input logic [15:0] d, input logic [3:0] a,
                            input logic [2:0] o, input logic [3:0] t, input logic [15:0] exp);
    drive(1'b1, d, a, o, t);
    check({name, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    idle();
    for (int c = 1; c < SHW; c++) begin
      check({name, "_early_valid"}, 32'(out_valid), 32'd0);
      tick();
    end
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_data"}, 32'(out_data), 32'(exp));
    check({name, "_tag"}, 32'(out_tag), 32'(t));
    tick();
    check({name, "_drained"}, 32'(out_valid), 32'd0);
  endtask

  typedef struct {
    string       name;
    logic [15:0] data;
    logic [3:0]  amt;
    logic [2:0]  op;
    logic [3:0]  tag;
    logic [15:0] exp;
  } vec_t;

  localparam int NVEC = 23;
  vec_t vecs [NVEC] = '{
    '{"rol_8001_1",   16'h8001, 4'd1,  3'd0, 4'h1, 16'h0003},
    '{"ror_8001_4",   16'h8001, 4'd4,  3'd1, 4'h2, 16'h1800},
    '{"sll_ffff_8",   16'hFFFF, 4'd8,  3'd2, 4'h3, 16'hFF00},
    '{"srl_8000_15",  16'h8000, 4'd15, 3'd3, 4'h4, 16'h0001},
    '{"sra_8000_15",  16'h8000, 4'd15, 3'd4, 4'h5, 16'hFFFF},
    '{"sra_4000_2",   16'h4000, 4'd2,  3'd4, 4'h6, 16'h1000},
    '{"srl_4000_2",   16'h4000, 4'd2,  3'd3, 4'h7, 16'h1000},
    '{"rol_8001_15",  16'h8001, 4'd15, 3'd0, 4'h8, 16'hC000},
    '{"ror_0001_15",  16'h0001, 4'd15, 3'd1, 4'h9, 16'h0002},
    '{"sll_0001_15",  16'h0001, 4'd15, 3'd2, 4'hA, 16'h8000},
    '{"sra_7fff_15",  16'h7FFF, 4'd15, 3'd4, 4'hB, 16'h0000},
    '{"srl_ffff_15",  16'hFFFF, 4'd15, 3'd3, 4'hC, 16'h0001},
    '{"rol_1234_4",   16'h1234, 4'd4,  3'd0, 4'hD, 16'h2341},
    '{"ror_1234_4",   16'h1234, 4'd4,  3'd1, 4'hE, 16'h4123},
    '{"sll_1234_4",   16'h1234, 4'd4,  3'd2, 4'hF, 16'h2340},
    '{"srl_1234_4",   16'h1234, 4'd4,  3'd3, 4'h0, 16'h0123},
    '{"sra_9234_4",   16'h9234, 4'd4,  3'd4, 4'h1, 16'hF923},
    '{"pass7_1234_5", 16'h1234, 4'd5,  3'd7, 4'h3, 16'h1234},
    '{"pass5_abcd_9", 16'hABCD, 4'd9,  3'd5, 4'h6, 16'hABCD},
    '{"rol_a5c3_0",   16'hA5C3, 4'd0,  3'd0, 4'h2, 16'hA5C3},
    '{"ror_a5c3_0",   16'hA5C3, 4'd0,  3'd1, 4'h4, 16'hA5C3},
    '{"sll_a5c3_0",   16'hA5C3, 4'd0,  3'd2, 4'h8, 16'hA5C3},
    '{"sra_a5c3_0",   16'hA5C3, 4'd0,  3'd4, 4'hC, 16'hA5C3}
  };

  // ---------------------------------------------------------------- stimulus
  initial begin
    reset     = 1'b1;
    out_ready = 1'b0;
    idle();

    // reset state, held with out_ready low; in_ready must still be high
    tick();
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", 32'(out_data), 32'd0);
    check("reset_out_tag", 32'(out_tag), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    tick();
    reset     = 1'b0;
    out_ready = 1'b1;
    tick();
    check("post_reset_in_ready", 32'(in_ready), 32'd1);
    check("post_reset_out_valid", 32'(out_valid), 32'd0);

    // single operands: every op, amt 0 and amt 15 edges, pass-through codes
    for (int v = 0; v < NVEC; v++) begin
      run_single(vecs[v].name, vecs[v].data, vecs[v].amt, vecs[v].op,
                 vecs[v].tag, vecs[v].exp);
    end

    // streaming: 16 back-to-back ROL of 0x0001 by 0..15, tags 0..15
    for (int c = 0; c < 19; c++) begin
      if (c < 16) drive(1'b1, 16'h0001, 4'(c), 3'd0, 4'(c));
      else        idle();
      tick();
      if (c >= 3) begin
        check("stream_valid", 32'(out_valid), 32'd1);
        check("stream_data", 32'(out_data), 32'(16'h0001 << (c - 3)));
        check("stream_tag", 32'(out_tag), 32'(c - 3));
      end
    end
    idle();
    tick();
    check("stream_drained", 32'(out_valid), 32'd0);

    // backpressure: fill the pipe with four ROR-by-4 operands
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'h0120 + 16'(i), 4'd4, 3'd1, 4'(8 + i));
      exp_q.push_back(16'h0012 | (16'(i) << 12));
      exp_tag_q.push_back(4'(8 + i));
      tick();
    end
    // A fifth operand waits at the input while the output is blocked.
    drive(1'b1, 16'h0125, 4'd4, 3'd1, 4'hD);
    out_ready = 1'b0;
    #1;
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_data", 32'(out_data), 32'(exp_q[0]));
      check("bp_hold_tag", 32'(out_tag), 32'(exp_tag_q[0]));
      check("bp_hold_in_ready", 32'(in_ready), 32'd0);
    end
    // Release: the output transfer and the waiting input happen on the same
    // edge.
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    exp_q.push_back(16'h5012);
    exp_tag_q.push_back(4'hD);
    void'(exp_q.pop_front());
    void'(exp_tag_q.pop_front());
    tick();
    idle();
    while (exp_q.size() > 0) begin
      check("bp_drain_valid", 32'(out_valid), 32'd1);
      check("bp_drain_data", 32'(out_data), 32'(exp_q.pop_front()));
      check("bp_drain_tag", 32'(out_tag), 32'(exp_tag_q.pop_front()));
      tick();
    end
    check("bp_no_duplicate", 32'(out_valid), 32'd0);

    // reset with three operands in flight
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'h00FF, 4'd1, 3'd2, 4'(1 + i));
      tick();
    end
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_out_data", 32'(out_data), 32'd0);
    check("flush_out_tag", 32'(out_tag), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    for (int c = 0; c < 6; c++) begin
      tick();
      check("flush_no_ghost", 32'(out_valid), 32'd0);
    end
    run_single("after_flush_ror", 16'h00F0, 4'd4, 3'd1, 4'h7, 16'h000F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/barrel_shifter_pipe.md
Name: barrel_shifter_pipe

Overview:
Parametrised, pipelined barrel shifter/rotator for the datapath. It supports rotate left/right, logical left/right shift, and arithmetic right shift on a WIDTH-bit operand. It replaces fixed 8-bit combinational rotators where timing needs registered stages and downstream needs valid/ready flow control. A sideband tag travels with each operand so results can be matched to their requests.

Parameters:
WIDTH, 16, operand width; must be a power of 2 and at least 2.
TAG_W, 4, width of the sideband tag carried alongside each operand.
SHW, $clog2(WIDTH), shift-amount width; derived, never overridden.

Ports:
clk  input  1  single clock; all state updates on its rising edge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  operand presented this cycle.
in_ready  output  1  block can accept an operand this cycle.
in_data  input  WIDTH  operand.
in_amt  input  SHW  shift/rotate amount, 0..WIDTH-1.
in_op  input  3  operation select: 000 ROL, 001 ROR, 010 SLL, 011 SRL, 100 SRA; 101-111 pass-through.
in_tag  input  TAG_W  sideband, returned unchanged.
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts the result.
out_data  output  WIDTH  result.
out_tag  output  TAG_W  tag of the result.

Behaviour:
- Pipeline structure
  - SHW mux stages; stage j shifts by 2^j when amt bit j is 1.
  - Every stage is registered, each with its own valid bit, data, remaining amt/op and tag.
  - Latency is exactly SHW cycles from an accepted input to out_valid, with no stall in between (WIDTH=16 gives 4 cycles).
- Functions, k = in_amt, indices mod WIDTH:
  - ROL: out[i] = in[(i-k) mod WIDTH].
  - ROR: out[i] = in[(i+k) mod WIDTH].
  - SLL: zero fill from the LSB side.
  - SRL: zero fill from the MSB side.
  - SRA: fill with in[WIDTH-1].
  - k=0 returns the operand unchanged for every op.
  - Pass-through codes (101-111) return in_data unchanged, regardless of in_amt.
- Handshake
  - Transfer on the input side occurs when in_valid && in_ready.
  - Transfer on the output side occurs when out_valid && out_ready.
  - advance = out_ready || !out_valid.
  - in_ready = advance (purely combinational on out_ready and out_valid).
  - When advance=1, all stages shift one step. Stage 0 loads the input if one was accepted, otherwise a bubble (valid=0).
  - When advance=0, all stage registers hold.
  - Bubbles are not compressed. Throughput is 1 result/cycle while out_ready=1.
  - out_data and out_tag stay stable while out_valid=1 and out_ready=0.
  - in_data and in_amt are ignored when in_valid=0.
- Reset
  - While reset=1 at a clock edge: every stage valid bit clears, and out_valid, out_data and out_tag go to 0.
  - in_ready is 1 during and right after reset.
  - Reset mid-operation discards all in-flight operands; no partial result is emitted.
- Boundaries and corner cases
  - A simultaneous output transfer and input accept on a full pipe is legal and loses nothing.
  - SRA on a positive operand equals SRL.
  - The result at shift amount WIDTH-1 must be correct for every op (e.g. SRA of the MSB gives all ones).
  - A tag change between back-to-back operands must track its own data.

Test Plan:
- WIDTH=16, ROL 0x8001 by 1 -> 0x0003; ROR 0x8001 by 4 -> 0x1800; each appears exactly 4 cycles after accept, tag intact.
- SLL 0xFFFF by 8 -> 0xFF00; SRL 0x8000 by 15 -> 0x0001; SRA 0x8000 by 15 -> 0xFFFF; SRA 0x4000 by 2 -> 0x1000.
- Streaming with out_ready=1: 16 back-to-back ROL of 0x0001 by 0..15 with tags 0..15 -> consecutive results 1<<k, one per cycle, tags in order.
- Backpressure: fill the pipe, then hold out_ready=0 for 5 cycles. Required: in_ready=0, out_data/out_tag stable. Release -> no loss or duplication.
- Pass-through op 111 with amt 5 on 0x1234 -> 0x1234. Amt 0 on all ops -> operand unchanged.
- Assert reset for 1 cycle with 3 operands in flight -> out_valid=0 next cycle, outputs 0, none of the 3 results ever emitted, and the next accepted operand returns correctly.
